// File: rtl/rtc_snapshot_master.sv
`default_nettype none
// ============================================================================
//  Module   : rtc_snapshot_master
//  Purpose  : Bus initiator that drives the RTC register block. It runs a
//             coherent date/time snapshot, re-reading the date when it rolls
//             over in the middle of a read, and an atomic time set that
//             disables the RTC, writes date and time, then re-enables it.
//  Options  : RTC_SNAP_ALARM_EN adds alarm date/time writes to the set
//             sequence and forces CTRL bit1.
//  Revision : 1.0  initial release
// ============================================================================
module rtc_snapshot_master #(
  parameter logic [31:0] RTC_BASE  = 32'h8100_9000,
  parameter logic [3:0]  MAX_RETRY = 4'd3,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_read,
  input  logic        start_set,
  input  logic [31:0] set_date,
  input  logic [31:0] set_time,
  input  logic [31:0] set_ctrl,
`ifdef RTC_SNAP_ALARM_EN
  input  logic [31:0] set_alarm_date,
  input  logic [31:0] set_alarm_time,
`endif
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] snap_date,
  output logic [31:0] snap_time,
  output logic        mem_valid,
  output logic        mem_instr,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata
);

  // Register offsets inside the RTC map
  localparam logic [31:0] OFF_CTRL  = 32'h00;
  localparam logic [31:0] OFF_DATE  = 32'h04;
  localparam logic [31:0] OFF_TIME  = 32'h08;
  localparam logic [31:0] OFF_RDATE = 32'h14;
  localparam logic [31:0] OFF_RTIME = 32'h18;
`ifdef RTC_SNAP_ALARM_EN
  localparam logic [31:0] OFF_ADATE = 32'h0C;
  localparam logic [31:0] OFF_ATIME = 32'h10;
  localparam logic [31:0] CTRL_FORCE = 32'h0000_0003;
`else
  localparam logic [31:0] CTRL_FORCE = 32'h0000_0001;
`endif

  // Timeout counter only needs to reach TIMEOUT-1
  localparam int          TW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TLAST = TW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
  localparam bit          TMO_EN = (TIMEOUT != 0);

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    RD_D0 = 4'd1,
    RD_T  = 4'd2,
    RD_D1 = 4'd3,
    WR_C0 = 4'd4,
    WR_D  = 4'd5,
    WR_T  = 4'd6,
    WR_C1 = 4'd7,
    GAP   = 4'd8,
    DONE  = 4'd9,
    WR_AD = 4'd10,
    WR_AT = 4'd11
  } state_t;

  state_t state, next_state, gap_ret, gap_target, follow;

  logic          is_bus, bus_write, ack, timeout_hit, accept;
  logic [31:0]   bus_addr, bus_wdata;
  logic [TW-1:0] tcnt;
  logic [3:0]    retry;
  logic [31:0]   date0, time_tmp;
  logic [31:0]   lat_date, lat_time, lat_ctrl;
`ifdef RTC_SNAP_ALARM_EN
  logic [31:0]   lat_adate, lat_atime;
`endif

  assign mem_instr   = 1'b0;
  assign busy        = (state != IDLE);
  assign done        = (state == DONE);
  assign ack         = mem_valid && mem_ready;
  assign timeout_hit = TMO_EN && mem_valid && !mem_ready && (tcnt == TLAST);
  assign accept      = (state == IDLE) && (start_set || start_read);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and per-state bus request decode
  always_comb begin
    next_state = state;
    gap_target = gap_ret;
    follow     = DONE;
    is_bus     = 1'b0;
    bus_write  = 1'b0;
    bus_addr   = RTC_BASE;
    bus_wdata  = 32'h0;
    case (state)
      IDLE: begin
        // Set has priority; a simultaneous read request is dropped
        if (start_set) begin
          next_state = WR_C0;
        end else if (start_read) begin
          next_state = RD_D0;
        end
      end
      RD_D0: begin
        is_bus   = 1'b1;
        bus_addr = RTC_BASE + OFF_RDATE;
        follow   = RD_T;
      end
      RD_T: begin
        is_bus   = 1'b1;
        bus_addr = RTC_BASE + OFF_RTIME;
        follow   = RD_D1;
      end
      RD_D1: begin
        is_bus   = 1'b1;
        bus_addr = RTC_BASE + OFF_RDATE;
        // Date stable or retries used up: finish; otherwise run another pass
        follow   = ((mem_rdata == date0) || (retry == MAX_RETRY)) ? DONE : RD_D0;
      end
      WR_C0: begin
        is_bus    = 1'b1;
        bus_write = 1'b1;
        bus_addr  = RTC_BASE + OFF_CTRL;
        follow    = WR_D;
      end
      WR_D: begin
        is_bus    = 1'b1;
        bus_write = 1'b1;
        bus_addr  = RTC_BASE + OFF_DATE;
        bus_wdata = lat_date;
        follow    = WR_T;
      end
      WR_T: begin
        is_bus    = 1'b1;
        bus_write = 1'b1;
        bus_addr  = RTC_BASE + OFF_TIME;
        bus_wdata = lat_time;
`ifdef RTC_SNAP_ALARM_EN
        follow    = WR_AD;
`else
        follow    = WR_C1;
`endif
      end
`ifdef RTC_SNAP_ALARM_EN
      WR_AD: begin
        is_bus    = 1'b1;
        bus_write = 1'b1;
        bus_addr  = RTC_BASE + OFF_ADATE;
        bus_wdata = lat_adate;
        follow    = WR_AT;
      end
      WR_AT: begin
        is_bus    = 1'b1;
        bus_write = 1'b1;
        bus_addr  = RTC_BASE + OFF_ATIME;
        bus_wdata = lat_atime;
        follow    = WR_C1;
      end
`endif
      WR_C1: begin
        is_bus    = 1'b1;
        bus_write = 1'b1;
        bus_addr  = RTC_BASE + OFF_CTRL;
        bus_wdata = lat_ctrl;
        follow    = DONE;
      end
      GAP:     next_state = gap_ret;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase

    if (is_bus) begin
      if (timeout_hit) begin
        next_state = DONE;
      end else if (ack) begin
        if (follow == DONE) begin
          next_state = DONE;
        end else begin
          next_state = GAP;
          gap_target = follow;
        end
      end
    end
  end

  // Bus request registers, read captures, retry/timeout counters and status
  always_ff @(posedge clk) begin
    if (reset) begin
      gap_ret   <= IDLE;
      mem_valid <= 1'b0;
      mem_addr  <= 32'h0;
      mem_wdata <= 32'h0;
      mem_wstrb <= 4'h0;
      tcnt      <= '0;
      retry     <= 4'h0;
      err       <= 1'b0;
      date0     <= 32'h0;
      time_tmp  <= 32'h0;
      snap_date <= 32'h0;
      snap_time <= 32'h0;
      lat_date  <= 32'h0;
      lat_time  <= 32'h0;
      lat_ctrl  <= 32'h0;
`ifdef RTC_SNAP_ALARM_EN
      lat_adate <= 32'h0;
      lat_atime <= 32'h0;
`endif
    end else begin
      gap_ret <= gap_target;

      if (accept) begin
        err      <= 1'b0;
        retry    <= 4'h0;
        lat_date <= set_date;
        lat_time <= set_time;
        lat_ctrl <= set_ctrl | CTRL_FORCE;
`ifdef RTC_SNAP_ALARM_EN
        lat_adate <= set_alarm_date;
        lat_atime <= set_alarm_time;
`endif
      end

      if (is_bus && !mem_valid) begin
        // First cycle of a bus state: launch the request
        mem_valid <= 1'b1;
        mem_addr  <= bus_addr;
        mem_wdata <= bus_wdata;
        mem_wstrb <= bus_write ? 4'hF : 4'h0;
        tcnt      <= '0;
      end else if (mem_valid) begin
        if (mem_ready) begin
          mem_valid <= 1'b0;
          case (state)
            RD_D0: date0    <= mem_rdata;
            RD_T:  time_tmp <= mem_rdata;
            RD_D1: begin
              if (mem_rdata == date0) begin
                snap_date <= date0;
                snap_time <= time_tmp;
              end else if (retry == MAX_RETRY) begin
                err <= 1'b1;
              end else begin
                retry <= retry + 4'd1;
              end
            end
            default: ;
          endcase
        end else if (timeout_hit) begin
          mem_valid <= 1'b0;
          err       <= 1'b1;
        end else begin
          tcnt <= tcnt + 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire
